// File: rtl/sa_pkg.sv
// rtl/sa_pkg.sv - shared FSM encoding, Q-format defaults and saturating add
package sa_pkg;

  localparam int DW_DEF = 16;
  localparam int FW_DEF = 13;
  localparam int MAXW   = 64;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  // Operands arrive sign-extended to MAXW; the sum is clamped to a signed dw-bit range.
  function automatic logic signed [MAXW-1:0] sat_add(input logic signed [MAXW-1:0] a,
                                                     input logic signed [MAXW-1:0] b,
                                                     input int dw);
    logic signed [MAXW-1:0] s, hi, lo, r;
    s  = a + b;
    hi = (MAXW'(1) <<< (dw - 1)) - MAXW'(1);
    lo = ~hi;
    if (s > hi)      r = hi;
    else if (s < lo) r = lo;
    else             r = s;
    return r;
  endfunction

endpackage

// File: rtl/sa_ws_array_if.sv
// rtl/sa_ws_array_if.sv - weight, input-vector and result handshakes of the array
interface sa_ws_array_if #(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = sa_pkg::DW_DEF
);
  logic                    I_W_VLD;
  logic [$clog2(ROWS)-1:0] I_W_ROW;
  logic [COLS*DW-1:0]      I_W;
  logic                    O_W_RDY;
  logic                    I_X_VLD;
  logic [ROWS*DW-1:0]      I_X;
  logic                    O_X_RDY;
  logic                    O_Y_VLD;
  logic [COLS*DW-1:0]      O_Y;
  logic                    I_Y_RDY;
  logic                    O_BUSY;
  logic                    O_SAT;
  logic                    I_SAT_CLR;

  modport master (
    output I_W_VLD, I_W_ROW, I_W, I_X_VLD, I_X, I_Y_RDY, I_SAT_CLR,
    input  O_W_RDY, O_X_RDY, O_Y_VLD, O_Y, O_BUSY, O_SAT
  );

  modport slave (
    input  I_W_VLD, I_W_ROW, I_W, I_X_VLD, I_X, I_Y_RDY, I_SAT_CLR,
    output O_W_RDY, O_X_RDY, O_Y_VLD, O_Y, O_BUSY, O_SAT
  );
endinterface

// File: rtl/sa_pe.sv
// rtl/sa_pe.sv - weight-stationary PE: stored weight, Q-format MAC with saturation
module sa_pe
  import sa_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int FW = FW_DEF
) (
  input  logic                 I_CLK,
  input  logic                 I_RST_N,
  input  logic                 en,
  input  logic                 w_ld,
  input  logic signed [DW-1:0] w_in,
  input  logic signed [DW-1:0] x_in,
  input  logic signed [DW-1:0] psum_in,
  output logic signed [DW-1:0] x_out,
  output logic signed [DW-1:0] psum_out,
  output logic                 sat
);

  logic signed [DW-1:0]   w_q;
  logic signed [2*DW-1:0] prod;
  logic signed [MAXW-1:0] prod_sh, raw, sum;

  assign prod    = (2*DW)'(x_in) * (2*DW)'(w_q);
  assign prod_sh = MAXW'(prod) >>> FW;
  assign raw     = prod_sh + MAXW'(psum_in);
  assign sum     = sat_add(prod_sh, MAXW'(psum_in), DW);
  assign sat     = (sum != raw);

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N)  w_q <= '0;
    else if (w_ld) w_q <= w_in;
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      x_out    <= '0;
      psum_out <= '0;
    end else if (en) begin
      x_out    <= x_in;
      psum_out <= sum[DW-1:0];
    end
  end

endmodule

// File: rtl/sa_ws_array.sv
// rtl/sa_ws_array.sv - ROWSxCOLS weight-stationary systolic array with skew/deskew and stall control
module sa_ws_array
  import sa_pkg::*;
#(
  parameter int ROWS = 8,
  parameter int COLS = 8,
  parameter int DW   = DW_DEF,
  parameter int FW   = FW_DEF
) (
  input logic          I_CLK,
  input logic          I_RST_N,
  sa_ws_array_if.slave bus
);

  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = ROWS + COLS;
  localparam int CW    = $clog2(DEPTH + 1);

  state_t state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [DEPTH-1:0]     vld_q;
  logic                 en, w_rdy, x_rdy, w_acc, x_acc, y_hs, sat_q;
  logic [ROWS*COLS-1:0] sat_v;
  logic [COLS*DW-1:0]   y_q;
  logic signed [DW-1:0] xs [ROWS][COLS+1];
  logic signed [DW-1:0] ps [ROWS+1][COLS];

  // A presented but unaccepted result freezes the whole pipeline.
  assign en    = !(vld_q[DEPTH-1] && !bus.I_Y_RDY);
  assign w_rdy = (cnt_q == '0);
  assign w_acc = bus.I_W_VLD && w_rdy;
  assign x_rdy = en && !w_acc;
  assign x_acc = bus.I_X_VLD && x_rdy;
  assign y_hs  = vld_q[DEPTH-1] && bus.I_Y_RDY;

  assign bus.O_W_RDY = w_rdy;
  assign bus.O_X_RDY = x_rdy;
  assign bus.O_Y_VLD = vld_q[DEPTH-1];
  assign bus.O_Y     = y_q;
  assign bus.O_BUSY  = (cnt_q != '0);
  assign bus.O_SAT   = sat_q;

  for (genvar r = 0; r < ROWS; r++) begin : g_skew
    logic signed [DW-1:0] x_raw;
    // Bubbles inject zeros so idle slots never add to partial sums or flag saturation.
    assign x_raw = x_acc ? bus.I_X[r*DW +: DW] : '0;
    if (r == 0) begin : g_direct
      assign xs[r][0] = x_raw;
    end else begin : g_dly
      logic signed [DW-1:0] sr [r];
      always_ff @(posedge I_CLK or negedge I_RST_N) begin
        if (!I_RST_N) begin
          for (int i = 0; i < r; i++) sr[i] <= '0;
        end else if (en) begin
          sr[0] <= x_raw;
          for (int i = 1; i < r; i++) sr[i] <= sr[i-1];
        end
      end
      assign xs[r][0] = sr[r-1];
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_top
    assign ps[0][c] = '0;
  end

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      sa_pe #(.DW(DW), .FW(FW)) u_pe (
        .I_CLK    (I_CLK),
        .I_RST_N  (I_RST_N),
        .en       (en),
        .w_ld     (w_acc && (bus.I_W_ROW == RW'(r))),
        .w_in     (bus.I_W[c*DW +: DW]),
        .x_in     (xs[r][c]),
        .psum_in  (ps[r][c]),
        .x_out    (xs[r][c+1]),
        .psum_out (ps[r+1][c]),
        .sat      (sat_v[r*COLS+c])
      );
    end
  end

  // Column c waits COLS-1-c cycles plus one shared output stage.
  for (genvar c = 0; c < COLS; c++) begin : g_deskew
    logic signed [DW-1:0] dq [COLS-c];
    always_ff @(posedge I_CLK or negedge I_RST_N) begin
      if (!I_RST_N) begin
        for (int i = 0; i < COLS - c; i++) dq[i] <= '0;
      end else if (en) begin
        dq[0] <= ps[ROWS][c];
        for (int i = 1; i < COLS - c; i++) dq[i] <= dq[i-1];
      end
    end
    assign y_q[c*DW +: DW] = dq[COLS-c-1];
  end

  always_comb begin
    cnt_d = cnt_q;
    if (x_acc && !y_hs)      cnt_d = cnt_q + CW'(1);
    else if (!x_acc && y_hs) cnt_d = cnt_q - CW'(1);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (w_acc) state_d = S_LOAD;
              else if (x_acc) state_d = S_RUN;
      S_LOAD: if (!bus.I_W_VLD) state_d = x_acc ? S_RUN : S_IDLE;
      S_RUN:  if (cnt_d == '0) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge I_CLK or negedge I_RST_N) begin
    if (!I_RST_N) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      vld_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (en) vld_q <= {vld_q[DEPTH-2:0], x_acc};
      if (en && |sat_v)       sat_q <= 1'b1;
      else if (bus.I_SAT_CLR) sat_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sa_ws_array.sv
// tb/tb_sa_ws_array.sv - self-checking bench for sa_ws_array against a matrix-level reference
module tb_sa_ws_array;
  import sa_pkg::*;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int DW   = 16;
  localparam int FW   = 13;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sa_ws_array_if #(.ROWS(ROWS), .COLS(COLS), .DW(DW)) bus_if ();
  sa_ws_array #(.ROWS(ROWS), .COLS(COLS), .DW(DW), .FW(FW)) dut (
    .I_CLK   (clk),
    .I_RST_N (rst_n),
    .bus     (bus_if)
  );

  int checks = 0;
  int failures = 0;
  int wm [ROWS][COLS];
  logic [63:0] exp_q [$];
  bit model_sat;
  bit last_xa, last_wa, last_xrdy, seen_vld;
  int wa_qsize, n_out;
  logic [63:0] last_y;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: Y[c] = running sum over rows of floor(x*w / 2^FW), clamped at every row.
  function automatic logic [63:0] model_y(input logic [63:0] xv);
    logic [63:0] y;
    longint acc, p, hi, lo;
    hi = (longint'(1) << (DW - 1)) - 1;
    lo = -hi - 1;
    y = '0;
    for (int c = 0; c < COLS; c++) begin
      acc = 0;
      for (int r = 0; r < ROWS; r++) begin
        p = (longint'($signed(xv[r*DW +: DW])) * longint'(wm[r][c])) >>> FW;
        acc = acc + p;
        if (acc > hi) begin acc = hi; model_sat = 1'b1; end
        else if (acc < lo) begin acc = lo; model_sat = 1'b1; end
        y[c*DW +: DW] = acc[DW-1:0];
      end
    end
    return y;
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] rand_wrow();
    logic [63:0] v;
    int e;
    for (int c = 0; c < COLS; c++) begin
      e = int'($urandom_range(0, 16383)) - 8192;
      v[c*DW +: DW] = e[DW-1:0];
    end
    return v;
  endfunction

  task automatic step();
    @(negedge clk);
    last_xa   = bus_if.I_X_VLD && bus_if.O_X_RDY;
    last_wa   = bus_if.I_W_VLD && bus_if.O_W_RDY;
    last_xrdy = bus_if.O_X_RDY;
    seen_vld  = bus_if.O_Y_VLD;
    last_y    = bus_if.O_Y;
    wa_qsize  = exp_q.size();
    if (rst_n) begin
      chk("w_rdy", bus_if.O_W_RDY, exp_q.size() == 0);
      chk("busy", bus_if.O_BUSY, exp_q.size() != 0);
    end
    if (bus_if.O_Y_VLD) begin
      if (exp_q.size() == 0) chk("spurious_y", bus_if.O_Y_VLD, 0);
      else if (!bus_if.I_Y_RDY) chk("stall_hold", bus_if.O_Y, exp_q[0]);
      else begin
        chk("y", bus_if.O_Y, exp_q.pop_front());
        n_out++;
      end
    end
    if (last_xa) exp_q.push_back(model_y(bus_if.I_X));
    if (last_wa)
      for (int c = 0; c < COLS; c++)
        wm[bus_if.I_W_ROW][c] = int'($signed(bus_if.I_W[c*DW +: DW]));
    @(posedge clk);
    #1;
  endtask

  task automatic write_row(input int r, input logic [63:0] row);
    int n = 0;
    bus_if.I_W_VLD = 1'b1;
    bus_if.I_W_ROW = r[1:0];
    bus_if.I_W     = row;
    do begin step(); n++; end while (!last_wa && n < 60);
    bus_if.I_W_VLD = 1'b0;
    chk("w_accept", last_wa, 1);
  endtask

  task automatic send_x(input logic [63:0] v);
    int n = 0;
    bus_if.I_X_VLD = 1'b1;
    bus_if.I_X     = v;
    do begin step(); n++; end while (!last_xa && n < 40);
    bus_if.I_X_VLD = 1'b0;
    chk("x_accept", last_xa, 1);
  endtask

  task automatic drain();
    int n = 0;
    bus_if.I_Y_RDY = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin step(); n++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic reset_outputs(input string tag);
    chk({tag, "_y_vld"}, bus_if.O_Y_VLD, 0);
    chk({tag, "_y"}, bus_if.O_Y, 0);
    chk({tag, "_busy"}, bus_if.O_BUSY, 0);
    chk({tag, "_sat"}, bus_if.O_SAT, 0);
    chk({tag, "_w_rdy"}, bus_if.O_W_RDY, 1);
    chk({tag, "_x_rdy"}, bus_if.O_X_RDY, 1);
  endtask

  task automatic clear_sat();
    bus_if.I_SAT_CLR = 1'b1;
    step();
    bus_if.I_SAT_CLR = 1'b0;
    model_sat = 1'b0;
    step();
    chk("sat_clr", bus_if.O_SAT, model_sat);
  endtask

  initial begin
    int lat, base, n;
    bus_if.I_W_VLD = 0; bus_if.I_W_ROW = '0; bus_if.I_W = '0;
    bus_if.I_X_VLD = 0; bus_if.I_X = '0; bus_if.I_Y_RDY = 1; bus_if.I_SAT_CLR = 0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 0;
    model_sat = 0;
    n_out = 0;

    #12;
    reset_outputs("rst");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Identity weights and the fixed latency.
    for (int r = 0; r < ROWS; r++) write_row(r, 64'h2000 << (r * DW));
    send_x(64'h0800_E000_1000_2000);
    lat = 0;
    do begin step(); lat++; end while (!seen_vld && lat < 40);
    chk("ident_lat", lat, ROWS + COLS);
    chk("ident_y", last_y, 64'h0800_E000_1000_2000);
    drain();

    // Full-scale saturation and sticky flag.
    for (int r = 0; r < ROWS; r++) write_row(r, 64'h7FFF_7FFF_7FFF_7FFF);
    send_x(64'h7FFF_7FFF_7FFF_7FFF);
    drain();
    chk("sat_y", last_y, 64'h7FFF_7FFF_7FFF_7FFF);
    chk("sat_flag", bus_if.O_SAT, 1);
    clear_sat();

    // Back-to-back vectors with a 3-cycle downstream stall.
    for (int r = 0; r < ROWS; r++) write_row(r, rand_wrow());
    base = n_out;
    bus_if.I_X_VLD = 1'b1;
    for (int i = 0; i < 6; i++) begin
      bus_if.I_X = rand64();
      step();
      chk("tput", last_xa, 1);
    end
    bus_if.I_X_VLD = 1'b0;
    n = 0;
    while (n_out < base + 2 && n < 40) begin step(); n++; end
    bus_if.I_Y_RDY = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_x_rdy", last_xrdy, 0);
      chk("stall_vld", seen_vld, 1);
    end
    drain();
    chk("n_results", n_out - base, 6);
    chk("sat_b2b", bus_if.O_SAT, model_sat);
    clear_sat();

    // Weight write held off until the last in-flight result leaves.
    bus_if.I_X_VLD = 1'b1;
    for (int i = 0; i < 3; i++) begin bus_if.I_X = rand64(); step(); end
    bus_if.I_X_VLD = 1'b0;
    base = n_out;
    write_row(2, rand_wrow());
    chk("w_held_q", wa_qsize, 0);
    chk("w_held_out", n_out - base, 3);
    send_x(rand64());
    drain();

    // Random valid/ready traffic.
    for (int i = 0; i < 40; i++) begin
      bus_if.I_X_VLD = 1'($urandom_range(0, 1));
      bus_if.I_X     = rand64();
      bus_if.I_Y_RDY = ($urandom_range(0, 3) != 0);
      step();
    end
    bus_if.I_X_VLD = 1'b0;
    drain();
    chk("sat_rand", bus_if.O_SAT, model_sat);
    clear_sat();

    // Reset with three vectors in flight.
    bus_if.I_X_VLD = 1'b1;
    for (int i = 0; i < 3; i++) begin bus_if.I_X = rand64(); step(); end
    bus_if.I_X_VLD = 1'b0;
    step();
    rst_n = 1'b0;
    exp_q.delete();
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) wm[r][c] = 0;
    model_sat = 1'b0;
    #1;
    reset_outputs("mid_rst");
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_rst_vld", seen_vld, 0);
    end
    chk("post_rst_state", 64'(dut.state_q), 64'(S_IDLE));
    send_x(rand64());
    drain();
    chk("zero_w_y", last_y, 0);

    // Simultaneous weight write and vector in S_IDLE.
    bus_if.I_W_VLD = 1'b1; bus_if.I_W_ROW = 2'd1; bus_if.I_W = rand_wrow();
    bus_if.I_X_VLD = 1'b1; bus_if.I_X = rand64();
    step();
    chk("prio_w_acc", last_wa, 1);
    chk("prio_x_rdy", last_xrdy, 0);
    chk("prio_state_load", 64'(dut.state_q), 64'(S_LOAD));
    bus_if.I_W_VLD = 1'b0;
    step();
    chk("prio_x_acc", last_xa, 1);
    chk("prio_state_run", 64'(dut.state_q), 64'(S_RUN));
    bus_if.I_X_VLD = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sa_ws_array.md
SA_WS_ARRAY -- requirements
Module: sa_ws_array

Interface
REQ-001 SHALL have parameter ROWS, default 8: array rows, equal to the input vector length (2..64).
REQ-002 SHALL have parameter COLS, default 8: array columns, equal to the output vector length (2..64).
REQ-003 SHALL have parameter DW, default 16: signed data width, two's complement.
REQ-004 SHALL have parameter FW, default 13: fraction bits, giving Q2.13 at the defaults.
REQ-005 SHALL have port I_CLK, input, 1 bit: clock, rising edge.
REQ-006 SHALL have port I_RST_N, input, 1 bit: reset, asynchronous, active-low.
REQ-007 SHALL have port I_W_VLD, input, 1 bit: weight-row write request.
REQ-008 SHALL have port I_W_ROW, input, $clog2(ROWS) bits: index of the weight row to write.
REQ-009 SHALL have port I_W, input, COLS*DW bits: weight row; column c is at bits [c*DW +: DW].
REQ-010 SHALL have port O_W_RDY, output, 1 bit: weight write accepted when I_W_VLD and O_W_RDY are both high.
REQ-011 SHALL have port I_X_VLD, input, 1 bit: input vector valid.
REQ-012 SHALL have port I_X, input, ROWS*DW bits: input vector; element r is at bits [r*DW +: DW].
REQ-013 SHALL have port O_X_RDY, output, 1 bit: input vector accepted when I_X_VLD and O_X_RDY are both high.
REQ-014 SHALL have port O_Y_VLD, output, 1 bit: result vector valid.
REQ-015 SHALL have port O_Y, output, COLS*DW bits: result vector; column c is at bits [c*DW +: DW].
REQ-016 SHALL have port I_Y_RDY, input, 1 bit: downstream ready.
REQ-017 SHALL have port O_BUSY, output, 1 bit: high while one or more accepted vectors are still in flight.
REQ-018 SHALL have port O_SAT, output, 1 bit: sticky saturation flag.
REQ-019 SHALL have port I_SAT_CLR, input, 1 bit: clears O_SAT.

Function
REQ-020 SHALL compute O_Y[c] = sum over r of (I_X[r] * W[r][c]), where W is the stored weight matrix (weight-stationary).
REQ-021 SHALL, in each PE, form the 2*DW-bit signed product, arithmetic-shift it right by FW (truncation toward minus infinity), add the partial sum from above, and saturate the result to the signed DW-bit range.
REQ-022 SHALL set O_SAT on any PE saturation; O_SAT holds until I_SAT_CLR; when saturation and I_SAT_CLR occur in the same cycle, set wins.
REQ-023 SHALL delay row r of the input by r cycles before it enters the array, and delay column c of the output by COLS-1-c cycles, so every element of a result vector is presented in the same cycle.
REQ-024 SHALL assert O_Y_VLD exactly ROWS+COLS cycles after the input vector is accepted, provided no stall occurs; results are returned in input order.
REQ-025 SHALL accept one input vector per cycle while unstalled (full throughput).
REQ-026 SHALL stall when O_Y_VLD=1 and I_Y_RDY=0: every skew, PE and deskew register holds its value, O_Y and O_Y_VLD remain stable, and O_X_RDY=0.
REQ-027 SHALL implement the control FSM states S_IDLE, S_LOAD and S_RUN.
REQ-028 SHALL transition S_IDLE->S_LOAD on an accepted weight write, and S_IDLE->S_RUN on an accepted input vector.
REQ-029 SHALL transition S_LOAD->S_IDLE in the first cycle with I_W_VLD=0, and S_LOAD->S_RUN on an accepted input vector when I_W_VLD=0.
REQ-030 SHALL transition S_RUN->S_IDLE when the in-flight count reaches 0.
REQ-031 SHALL track in-flight vectors with a counter of 0..ROWS+COLS: increment on accept, decrement on output handshake, and leave it unchanged when both occur in the same cycle.
REQ-032 SHALL drive O_W_RDY=1 only when the in-flight count is 0; weights SHALL NOT change under in-flight data.
REQ-033 SHALL give weight writes priority when I_W_VLD and I_X_VLD are asserted simultaneously in S_IDLE or S_LOAD: O_X_RDY=0 in that cycle.
REQ-034 SHALL make a written weight row visible to vectors accepted from the next cycle onward.
REQ-035 SHALL ignore I_X when I_X_VLD=0, inserting a bubble: no O_Y_VLD is generated for that slot.

Reset
REQ-036 SHALL, on reset assertion, asynchronously clear all weights, skew, PE and deskew registers, the in-flight counter and O_SAT to 0, and set the FSM to S_IDLE.
REQ-037 SHALL drive the outputs during reset to O_Y_VLD=0, O_Y=0, O_BUSY=0, O_SAT=0, O_W_RDY=1 and O_X_RDY=1.
REQ-038 SHALL discard in-flight vectors when reset is asserted mid-stream; no stale O_Y_VLD SHALL appear after reset release.

Structure
REQ-039 SHALL place the FSM state encoding, the saturating-add function and the Q-format constants (DW, FW defaults) in the shared package sa_pkg.
REQ-040 SHALL use a single sub-module, sa_pe (weight register, multiply, shift, saturating add, registered partial-sum and x-pass-through), instantiated ROWS*COLS times.

Verification
REQ-041 SHALL verify, with ROWS=COLS=4 and identity weights (0x2000 on the diagonal), that X=(0x2000,0x1000,0xE000,0x0800) produces Y=X with O_Y_VLD exactly 8 cycles after accept.
REQ-042 SHALL verify that all weights 0x7FFF with all X 0x7FFF produce Y=0x7FFF for every column and O_SAT=1; O_SAT SHALL clear after a one-cycle I_SAT_CLR pulse.
REQ-043 SHALL verify that 6 back-to-back vectors with I_Y_RDY held low for 3 cycles mid-stream yield 6 results, in order, with none lost, and O_X_RDY=0 during the stall.
REQ-044 SHALL verify that I_W_VLD asserted while O_BUSY=1 is held off (O_W_RDY=0) until the final result handshake, after which the next vector uses the new weights.
REQ-045 SHALL verify that I_RST_N pulsed low with 3 vectors in flight leaves O_Y_VLD=0 afterwards, all weights 0, and the FSM in S_IDLE.
REQ-046 SHALL verify that simultaneous I_W_VLD and I_X_VLD in S_IDLE cause the weight write to be accepted first and the vector to be accepted the next cycle.
